// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifetch_pkg;

    localparam int INSTR_WIDTH = 33;

    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        SQUASH = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch FIFO: flop storage with a combinational head, synchronous push/pop
// and a flush that empties it on the same edge.
module ifetch_fifo #(
    parameter int WIDTH = 49,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count_q == '0);
    assign pop_ok  = pop && !empty && !flush;
    // The fetch FSM keeps at most one read in flight and only starts one below
    // full, so a push never lands on a full FIFO.
    assign push_ok = push && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: single-outstanding memory reads into a prefetch FIFO.
// Optional IFETCH_STALL_COUNT_EN adds a saturating empty-cycle counter output.
module instruction_fetch #(
    parameter int ADDR_WIDTH                = 16,
    parameter int INSTR_WIDTH               = ifetch_pkg::INSTR_WIDTH,
    parameter int DEPTH                     = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   mem_req,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic                   mem_ack,
    input  logic [INSTR_WIDTH-1:0] mem_data,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   instruction_valid,
    output logic [ADDR_WIDTH-1:0]  instruction_pc,
    input  logic                   program_counter_inc,
    input  logic                   redirect,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc
`ifdef IFETCH_STALL_COUNT_EN
    ,
    output logic [15:0]            stall_count
`endif
);

    import ifetch_pkg::fetch_state_e;
    import ifetch_pkg::IDLE;
    import ifetch_pkg::REQ;
    import ifetch_pkg::SQUASH;
    import ifetch_pkg::NOP_INSTR;

    localparam int EW = INSTR_WIDTH + ADDR_WIDTH;
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;

    logic          fifo_push;
    logic          fifo_pop;
    logic [EW-1:0] fifo_head;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_addr_d = mem_addr_q;
        fifo_push  = 1'b0;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                end else if (fifo_count < CW'(DEPTH)) begin
                    state_d    = REQ;
                    mem_addr_d = fetch_pc_q;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_d = IDLE;
                    if (redirect) begin
                        fetch_pc_d = redirect_pc;
                    end else begin
                        fifo_push  = 1'b1;
                        fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(1);
                    end
                end else if (redirect) begin
                    // The bus request must stay stable, so the read is left to
                    // finish and its data thrown away.
                    state_d    = SQUASH;
                    fetch_pc_d = redirect_pc;
                end
            end
            SQUASH: begin
                if (redirect) fetch_pc_d = redirect_pc;
                if (mem_ack)  state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            mem_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign mem_req  = (state_q != IDLE);
    assign mem_addr = mem_addr_q;
    assign fifo_pop = program_counter_inc && !fifo_empty;

    ifetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect),
        .push      (fifo_push),
        .push_data ({mem_data, mem_addr_q}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign instruction_valid = !fifo_empty;
    assign instruction       = fifo_empty ? INSTR_WIDTH'(NOP_INSTR) : fifo_head[EW-1 -: INSTR_WIDTH];
    assign instruction_pc    = fifo_empty ? '0 : fifo_head[ADDR_WIDTH-1:0];

`ifdef IFETCH_STALL_COUNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (fifo_empty && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_q <= '0;
        else        stall_q <= stall_d;
    end

    assign stall_count = stall_q;
`endif

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch unit that feeds the control path: holds the fetch program counter and issues single-outstanding reads to instruction memory over a req/ack handshake. Returned words are buffered in a small prefetch FIFO, and the head is presented on `instruction` together with its address. The control path consumes one instruction per `program_counter_inc` pulse. A redirect flushes the buffer, squashes any in-flight read and restarts fetch at a new address.

## Interface
- `ADDR_WIDTH`, 16, instruction address width (word addressed)
- `INSTR_WIDTH`, 33, instruction word width; matches control path `instruction`
- `DEPTH`, 4, prefetch FIFO entries; power of two, ≥2
- `RESET_PC`, 0, fetch address after reset
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous and active-low
- `mem_req` out 1: memory read request, level
- `mem_addr` out ADDR_WIDTH: read address; stable while `mem_req` is high and unacked
- `mem_ack` in 1: read completes in any cycle with `mem_req && mem_ack`
- `mem_data` in INSTR_WIDTH: read data, valid in the completing cycle
- `instruction` out INSTR_WIDTH: FIFO head; all-zero (NOP) when empty
- `instruction_valid` out 1: FIFO non-empty
- `instruction_pc` out ADDR_WIDTH: address of the head instruction; 0 when empty
- `program_counter_inc` in 1: pop the head; ignored when `instruction_valid` is 0
- `redirect` in 1: flush and restart fetch, single-cycle pulse
- `redirect_pc` in ADDR_WIDTH: new fetch address, sampled when `redirect` is high
- `stall_count` out 16: only with `IFETCH_STALL_COUNT_EN`

## Operation
- FSM states:
  - IDLE: no request.
  - REQ: request pending, data kept.
  - SQUASH: request pending, data discarded.
- IDLE→REQ when FIFO count < DEPTH and no redirect; `mem_addr` = `fetch_pc`.
- REQ + ack: push {`mem_data`, `mem_addr`}, `fetch_pc` += 1 (wraps modulo 2^ADDR_WIDTH), →IDLE.
- REQ + redirect without ack: →SQUASH. `mem_req`/`mem_addr` are held until ack; `fetch_pc` ← `redirect_pc`.
- SQUASH + ack: data dropped, →IDLE.
- Redirect in the same cycle as ack: data dropped, `fetch_pc` ← `redirect_pc`, →IDLE.
- Redirect in any state: FIFO emptied the same edge; a redirect during SQUASH updates `fetch_pc` only.
- Pop and push in the same cycle: count unchanged. A pop with a full FIFO frees a slot for the next request.
- Redirect and pop in the same cycle: redirect wins, FIFO empty.
- Only one read is ever outstanding. FIFO overflow is impossible by construction.

## Timing
- Reset values:
  - `mem_req`=0, `mem_addr`=RESET_PC
  - `instruction`=0, `instruction_valid`=0, `instruction_pc`=0
  - `stall_count`=0
  - state IDLE, `fetch_pc`=RESET_PC
- First `mem_req` in the first cycle after `rst_n` deasserts.
- Ack in cycle N → `instruction_valid` at N+1. Back-to-back fetch gives one request every 2 cycles (IDLE→REQ bubble); zero-wait memory gives 1 instruction per 2 cycles.
- Pop at edge N → the next head is visible after edge N.
- Redirect at edge N → `instruction_valid`=0 after N. With no squash, the new request issues after N+1.
- Reset asserted mid-transaction: all state returns to reset values immediately; the pending memory read is abandoned.

## Configuration
- `IFETCH_STALL_COUNT_EN` defined:
  - Adds output `stall_count`, a 16-bit saturating counter (sticks at 0xFFFF).
  - Increments every cycle with `instruction_valid`=0 after reset; cleared only by reset.
- Not defined: port and logic absent; behaviour otherwise identical.

## Structure
- `ifetch_pkg`:
  - `INSTR_WIDTH`=33
  - `NOP_INSTR` (all zero)
  - FSM enum {IDLE, REQ, SQUASH}
- Sub-module `ifetch_fifo`:
  - Parameterized DEPTH/width, synchronous push/pop, flush input.
  - Outputs: count, head data, empty.

## Test plan
- Zero-wait memory returning `mem_data` = address + 0x100: instructions at pcs 0,1,2,3 appear in order with matching `instruction_pc`, and `mem_req` pulses every 2nd cycle.
- No pops, memory always acks: exactly 4 acks, then `mem_req` stays 0. One pop → exactly one more request at address 4.
- Ack delayed 5 cycles: `mem_addr` stays 0 and `mem_req` stays 1 throughout; `instruction_valid` rises the cycle after the ack.
- Redirect to 0x40 while a read of 2 is pending, ack 3 cycles later: the data for 2 never appears, the next request is 0x40, and the FIFO empties on the redirect edge.
- Redirect and pop in the same cycle with 3 entries: `instruction_valid`=0 next cycle. `fetch_pc` wraps from 0xFFFF to 0 without error.
- `rst_n` pulsed low mid-REQ: all outputs at reset values asynchronously, restart at RESET_PC. With `IFETCH_STALL_COUNT_EN`, `stall_count` = number of empty cycles.
